// File: rtl/svfloat_issue_unit.sv
// Issue front-end for the single-precision add/sub/mul/div units: accepts tagged
// commands, tracks them through the fixed unit latency and returns results in order.

module svfloat_unit #(
    parameter int         LATENCY = 2,
    parameter logic [1:0] OP      = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lhs_i,
    input  logic [31:0] rhs_i,
    output logic [31:0] res_o
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    endfunction

    // m = {hidden, 23 mantissa bits, guard, round, sticky}; round to nearest even,
    // denormal results flush to signed zero.
    function automatic logic [31:0] fp_pack(input logic s, input int e, input logic [26:0] m);
        logic [24:0] r;
        int          ee;
        r  = {1'b0, m[26:3]} + 25'(m[2] & (m[3] | m[1] | m[0]));
        ee = e;
        if (r[24]) begin
            r  = r >> 1;
            ee = ee + 1;
        end
        if (ee >= 255) return {s, 8'hFF, 23'd0};
        if (ee <= 0)   return {s, 31'd0};
        return {s, ee[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [26:0] mx, my;
        logic [27:0] sum;
        logic        st;
        int          d, e;
        st = 1'b0;
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a)) return (is_inf(b) && (a[31] != b[31])) ? QNAN : a;
        if (is_inf(b)) return b;
        if (a[30:0] < b[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        if (x[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
        mx = {1'b1, x[22:0], 3'b000};
        my = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
        d  = int'(x[30:23]) - int'(y[30:23]);
        if (d > 26) begin
            my = {26'd0, |my};
        end else begin
            st = |(my & ((27'd1 << d) - 27'd1));
            my = (my >> d) | {26'd0, st};
        end
        e   = int'(x[30:23]);
        sum = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        if (sum == 28'd0) return 32'd0;
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!sum[26]) begin
                sum = sum << 1;
                e   = e - 1;
            end
        end
        return fp_pack(x[31], e, sum[26:0]);
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          e;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) || is_inf(b))
            return (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? QNAN : {s, 8'hFF, 23'd0};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) e = e + 1;
        else       p = p << 1;
        return fp_pack(s, e, {p[47:22], |p[21:0]});
    endfunction

    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        logic        s, st;
        logic [49:0] n, dv;
        logic [26:0] q;
        int          e;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) return QNAN;
        if ((is_inf(a) && is_inf(b)) || (a[30:23] == 8'd0 && b[30:23] == 8'd0)) return QNAN;
        if (is_inf(a) || b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
        if (a[30:23] == 8'd0 || is_inf(b)) return {s, 31'd0};
        n  = {1'b1, a[22:0], 26'd0};
        dv = {26'd0, 1'b1, b[22:0]};
        q  = 27'(n / dv);
        st = (n % dv) != 50'd0;
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[26]) return fp_pack(s, e, {q[26:1], q[0] | st});
        return fp_pack(s, e - 1, {q[25:0], st});
    endfunction

    logic [31:0] res_c;

    always_comb begin
        case (OP)
            2'd0:    res_c = fp_add(lhs_i, rhs_i);
            2'd1:    res_c = fp_add(lhs_i, {~rhs_i[31], rhs_i[30:0]});
            2'd2:    res_c = fp_mul(lhs_i, rhs_i);
            default: res_c = fp_div(lhs_i, rhs_i);
        endcase
    end

    // The issue unit's operand register is the first latency stage, so the unit adds LATENCY-1.
    if (LATENCY == 1) begin : g_comb
        assign res_o = res_c;
    end else begin : g_pipe
        logic [31:0] pipe_q [LATENCY-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= res_c;
                for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign res_o = pipe_q[LATENCY-2];
    end
endmodule

module svfloat_issue_unit #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_lhs,
    input  logic [31:0]      req_rhs,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_op,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      lhs_q, rhs_q;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d, fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             trk_vld_q [LATENCY];
    logic [1:0]       trk_op_q  [LATENCY];
    logic [TAG_W-1:0] trk_tag_q [LATENCY];
    logic [1:0]       fifo_op_q  [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];
    logic [31:0]      fifo_res_q [DEPTH];
    logic [31:0]      unit_res   [4];
    logic             accept, push, pop;

    for (genvar g = 0; g < 4; g++) begin : g_unit
        svfloat_unit #(.LATENCY(LATENCY), .OP(2'(g))) u_unit (
            .clk  (clk),
            .rst_n(rst_n),
            .lhs_i(lhs_q),
            .rhs_i(rhs_q),
            .res_o(unit_res[g])
        );
    end

    // Credit check uses registered state only, so rsp_ready never reaches req_ready.
    assign req_ready = out_cnt_q < CNT_W'(DEPTH);
    assign accept    = req_valid && req_ready;
    assign busy      = out_cnt_q != '0;
    assign rsp_valid = fifo_cnt_q != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = trk_vld_q[LATENCY-1];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
        out_cnt_d  = out_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (accept && !pop) out_cnt_d = out_cnt_q + 1'b1;
        if (!accept && pop) out_cnt_d = out_cnt_q - 1'b1;
        if (push && !pop)   fifo_cnt_d = fifo_cnt_q + 1'b1;
        if (!push && pop)   fifo_cnt_d = fifo_cnt_q - 1'b1;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhs_q      <= '0;
            rhs_q      <= '0;
            out_cnt_q  <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                trk_vld_q[i] <= 1'b0;
                trk_op_q[i]  <= '0;
                trk_tag_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates let every stage read the pre-edge value of its neighbour.
            if (accept) begin
                lhs_q <= req_lhs;
                rhs_q <= req_rhs;
            end
            out_cnt_q    <= out_cnt_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            trk_vld_q[0] <= accept;
            trk_op_q[0]  <= req_op;
            trk_tag_q[0] <= req_tag;
            for (int i = 1; i < LATENCY; i++) begin
                trk_vld_q[i] <= trk_vld_q[i-1];
                trk_op_q[i]  <= trk_op_q[i-1];
                trk_tag_q[i] <= trk_tag_q[i-1];
            end
        end
    end

    // NOTE: FIFO storage has no reset; the count defines what is live and the outputs are gated by it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_ptr_q]  <= trk_op_q[LATENCY-1];
            fifo_tag_q[wr_ptr_q] <= trk_tag_q[LATENCY-1];
            fifo_res_q[wr_ptr_q] <= unit_res[trk_op_q[LATENCY-1]];
        end
    end

    assign rsp_op     = rsp_valid ? fifo_op_q[rd_ptr_q]  : '0;
    assign rsp_tag    = rsp_valid ? fifo_tag_q[rd_ptr_q] : '0;
    assign rsp_result = rsp_valid ? fifo_res_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_svfloat_issue_unit.sv
// Directed bench for svfloat_issue_unit: vector table plus hand-written sequences for
// latency, back-to-back issue, backpressure, full-FIFO push/pop and mid-operation reset.

module tb_svfloat_issue_unit;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]       req_op, rsp_op;
    logic [31:0]      req_lhs, req_rhs, rsp_result;
    logic [TAG_W-1:0] req_tag, rsp_tag;

    vec_t             tbl [5];
    rsp_t             exp_q [$];
    rsp_t             ent;
    logic [31:0]      cur_exp = '0;
    logic [TAG_W-1:0] tag_ctr;
    int               n_cmp = 0;
    int               n_err = 0;
    int               acc;

    always #5 clk = ~clk;

    svfloat_issue_unit #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_lhs   (req_lhs),
        .req_rhs   (req_rhs),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_op    (rsp_op),
        .rsp_tag   (rsp_tag),
        .rsp_result(rsp_result),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_op    = tbl[idx].op;
        req_lhs   = tbl[idx].lhs;
        req_rhs   = tbl[idx].rhs;
        req_tag   = tag;
        cur_exp   = tbl[idx].res;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 60 && busy; k++) tick;
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_left"}, exp_q.size(), 0);
    endtask

    // Reference model: outstanding = accepted-but-unpopped, head must equal the oldest one.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("req_ready_credit", req_ready, exp_q.size() < DEPTH);
            check("busy_model", busy, exp_q.size() != 0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", rsp_valid, 1'b0);
                end else begin
                    check("rsp_op", rsp_op, exp_q[0].op);
                    check("rsp_tag", rsp_tag, exp_q[0].tag);
                    check("rsp_result", rsp_result, exp_q[0].res);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                ent = '{op: req_op, tag: req_tag, res: cur_exp};
                exp_q.push_back(ent);
            end
        end
    end

    initial begin
        tbl[0] = '{2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};  // 1+2
        tbl[1] = '{2'd1, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000};  // 1-2
        tbl[2] = '{2'd2, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000};  // 3*2
        tbl[3] = '{2'd3, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000};  // 1/2
        tbl[4] = '{2'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};  // 0+0

        req_valid = 1'b0;
        req_op    = '0;
        req_lhs   = '0;
        req_rhs   = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_op", rsp_op, 2'd0);
        check("rst_rsp_tag", rsp_tag, '0);
        check("rst_rsp_result", rsp_result, 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // Single add: response visible exactly LATENCY edges after the accepting edge.
        drive(0, 4'd5);
        tick;
        req_valid = 1'b0;
        check("lat_valid_e0", rsp_valid, 1'b0);
        for (int k = 1; k <= LATENCY; k++) begin
            tick;
            check("lat_valid", rsp_valid, k == LATENCY);
        end
        check("single_result", rsp_result, 32'h4040_0000);
        check("single_tag", rsp_tag, 4'd5);
        tick;
        check("single_done_busy", busy, 1'b0);
        check("single_done_valid", rsp_valid, 1'b0);

        // Back-to-back sub/mul/div/add with tags 0..3, responses in consecutive cycles.
        for (int i = 0; i < LATENCY + 6; i++) begin
            if (i < 4) drive(i + 1, TAG_W'(i));
            else req_valid = 1'b0;
            tick;
            check("b2b_valid", rsp_valid, (i >= LATENCY) && (i < LATENCY + 4));
        end
        wait_idle("b2b");

        // Backpressure: exactly DEPTH accepts, then one pop re-enables exactly one accept.
        rsp_ready = 1'b0;
        tag_ctr   = '0;
        acc       = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            drive(i % 5, tag_ctr);
            if (req_ready) begin
                acc++;
                tag_ctr++;
            end
            tick;
        end
        check("bp_accepts", acc, DEPTH);
        check("bp_ready_low", req_ready, 1'b0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive((i + 2) % 5, tag_ctr);
            if (req_ready) begin
                acc++;
                tag_ctr++;
            end
            tick;
        end
        check("bp_one_more", acc, 1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("bp_drain");

        // Full FIFO with rsp_ready toggling under continuous requests.
        for (int i = 0; i < 40; i++) begin
            drive(i % 5, tag_ctr);
            rsp_ready = (i % 2 == 1);
            if (req_ready) tag_ctr++;
            tick;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("toggle_drain");

        // Reset with one buffered and two in flight.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i % 4, TAG_W'(10 + i));
            tick;
        end
        req_valid = 1'b0;
        check("pre_rst_valid", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1'b1);
        check("arst_rsp_valid", rsp_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_rsp_op", rsp_op, 2'd0);
        check("arst_rsp_tag", rsp_tag, '0);
        check("arst_rsp_result", rsp_result, 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < LATENCY + 2; k++) begin
            tick;
            check("post_rst_no_stale", rsp_valid, 1'b0);
        end
        drive(0, 4'd9);
        tick;
        req_valid = 1'b0;
        for (int k = 0; k < 20 && !rsp_valid; k++) tick;
        check("post_rst_rsp_valid", rsp_valid, 1'b1);
        check("post_rst_result", rsp_result, 32'h4040_0000);
        check("post_rst_tag", rsp_tag, 4'd9);
        wait_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
